// File: rtl/sram_1w1r_stream_fifo_pkg.sv
// sram_fifo_pkg: shared widths and types for the SRAM-backed stream FIFO.
package sram_fifo_pkg;
  localparam int DATA_WIDTH = 52;
  localparam int ADDR_WIDTH = 7;
  localparam int NUM_WMASKS = 4;
  localparam int SRAM_DEPTH = 1 << ADDR_WIDTH;
  localparam int OBUF_DEPTH = 2;
  localparam int COUNT_WIDTH = 8;
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [COUNT_WIDTH-1:0] cnt_t;
endpackage

// File: rtl/sram_1w1r_stream_fifo_obuf2.sv
// sram_fifo_obuf2: 2-entry output buffer that captures SRAM read data and presents a stable head.
module sram_fifo_obuf2
  import sram_fifo_pkg::*;
(
  input  logic       clk0,
  input  logic       rst0,
  input  logic       push,
  input  data_t      push_data,
  input  logic       pop,
  output data_t      head,
  output logic [1:0] cnt
);
  data_t e0, e1;
  assign head = e0;
  always_ff @(posedge clk0) begin
    if (rst0) cnt <= '0;
    else cnt <= cnt + 2'(push) - 2'(pop);
  end
  // e0 is the head; e1 only ever holds the second-oldest word
  always_ff @(posedge clk0) begin
    if (pop) e0 <= cnt[1] ? e1 : push_data;
    else if (push && cnt == 2'd0) e0 <= push_data;
    if (push && (pop ? cnt[1] : cnt != 2'd0)) e1 <= push_data;
  end
endmodule

// File: rtl/sram_1w1r_stream_fifo.sv
// sram_1w1r_stream_fifo: valid/ready FIFO wrapped around a 1W1R 128x52 SRAM macro,
// hiding the macro's read latency behind a 2-entry prefetch buffer.
module sram_1w1r_stream_fifo
  import sram_fifo_pkg::*;
(
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  data_t                 s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output data_t                 m_data,
  output cnt_t                  count,
  output logic                  sram_csb0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output addr_t                 sram_addr0,
  output data_t                 sram_din0,
  output logic                  sram_csb1,
  output addr_t                 sram_addr1,
  input  data_t                 sram_dout1
);
  addr_t wptr, rptr;
  cnt_t sram_cnt;
  logic rd_pend, push, pop, issue;
  logic [1:0] obuf_cnt;
  assign s_ready = sram_cnt < cnt_t'(SRAM_DEPTH);
  assign push = s_valid & s_ready & ~rst0;
  assign pop = m_valid & m_ready;
  // only prefetch when the word is guaranteed a buffer slot at capture time
  assign issue = ~rst0 & (sram_cnt != '0) &
                 ({1'b0, obuf_cnt} + {2'b0, rd_pend} < 3'd2 + {2'b0, pop});
  assign m_valid = obuf_cnt != 2'd0;
  assign count = sram_cnt + cnt_t'(obuf_cnt) + cnt_t'(rd_pend);
  assign sram_csb0 = ~push;
  assign sram_wmask0 = '1;
  assign sram_addr0 = wptr;
  assign sram_din0 = s_data;
  assign sram_csb1 = ~issue;
  assign sram_addr1 = rptr;
  always_ff @(posedge clk0) begin
    if (rst0) begin
      wptr <= '0;
      rptr <= '0;
      sram_cnt <= '0;
      rd_pend <= 1'b0;
    end else begin
      wptr <= wptr + addr_t'(push);
      rptr <= rptr + addr_t'(issue);
      sram_cnt <= sram_cnt + cnt_t'(push) - cnt_t'(issue);
      rd_pend <= issue;
    end
  end
  sram_fifo_obuf2 u_obuf (
    .clk0      (clk0),
    .rst0      (rst0),
    .push      (rd_pend),
    .push_data (sram_dout1),
    .pop       (pop),
    .head      (m_data),
    .cnt       (obuf_cnt)
  );
endmodule

// File: tb/tb_sram_1w1r_stream_fifo.sv
// tb_sram_1w1r_stream_fifo: directed + random checks of the SRAM stream FIFO against a queue model.
module tb_sram_1w1r_stream_fifo;
  import sram_fifo_pkg::*;
  localparam data_t POISON = 52'hBAD_0BAD_0BAD0;
  logic clk0 = 1'b0, rst0 = 1'b1, s_valid = 1'b0, m_ready = 1'b0;
  data_t s_data = '0;
  logic s_ready, m_valid, sram_csb0, sram_csb1;
  data_t m_data, sram_din0, sram_dout1;
  cnt_t count;
  logic [NUM_WMASKS-1:0] sram_wmask0;
  addr_t sram_addr0, sram_addr1;
  data_t mem [SRAM_DEPTH];
  data_t q[$];
  data_t held;
  logic stall_prev = 1'b0;
  int n_chk = 0, n_fail = 0, wr_idx = 0, rd_idx = 0;

  always #5 clk0 = ~clk0;

  sram_1w1r_stream_fifo dut (
    .clk0(clk0), .rst0(rst0), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .count(count),
    .sram_csb0(sram_csb0), .sram_wmask0(sram_wmask0), .sram_addr0(sram_addr0),
    .sram_din0(sram_din0), .sram_csb1(sram_csb1), .sram_addr1(sram_addr1),
    .sram_dout1(sram_dout1)
  );

  // Macro model: read data valid for the cycle after a read, poisoned otherwise
  always @(posedge clk0) begin
    if (!sram_csb0) mem[sram_addr0] <= sram_din0;
    sram_dout1 <= !sram_csb1 ? mem[sram_addr1] : POISON;
  end

  function automatic data_t rnd();
    return data_t'({$urandom(), $urandom()});
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic sv, input data_t sd, input logic mr);
    rst0 = r; s_valid = sv; s_data = sd; m_ready = mr;
    #1;
    if (r) chk("csb_in_reset", {62'd0, sram_csb0, sram_csb1}, 64'd3);
    else begin
      chk("count", 64'(count), 64'(q.size()));
      chk("wmask", 64'(sram_wmask0), 64'hf);
      chk("csb0", 64'(sram_csb0), 64'(!(s_valid && s_ready)));
      chk("s_ready_full", 64'(s_ready || q.size() >= 128), 64'd1);
      if (q.size() == 0) chk("idle", {62'd0, m_valid, sram_csb1}, 64'd1);
      else if (m_valid) chk("m_data", 64'(m_data), 64'(q[0]));
      if (!sram_csb0) begin
        chk("addr0", 64'(sram_addr0), 64'(wr_idx % SRAM_DEPTH));
        chk("din0", 64'(sram_din0), 64'(s_data));
      end
      if (!sram_csb1) begin
        chk("addr1", 64'(sram_addr1), 64'(rd_idx % SRAM_DEPTH));
        chk("rd_after_wr", 64'(rd_idx < wr_idx), 64'd1);
      end
      if (!sram_csb0 && !sram_csb1) chk("hazard", 64'(sram_addr0 == sram_addr1), 64'd0);
      if (stall_prev) begin
        chk("hold_valid", 64'(m_valid), 64'd1);
        chk("hold_data", 64'(m_data), 64'(held));
      end
    end
  endtask

  task automatic tick();
    if (rst0) begin
      q.delete(); wr_idx = 0; rd_idx = 0;
    end else begin
      if (s_valid && s_ready) begin q.push_back(s_data); wr_idx++; end
      if (m_valid && m_ready && q.size() != 0) void'(q.pop_front());
      if (!sram_csb1) rd_idx++;
    end
    stall_prev = !rst0 && m_valid && !m_ready;
    held = m_data;
    @(posedge clk0);
    @(negedge clk0);
  endtask

  task automatic cyc(input logic sv, input data_t sd, input logic mr);
    drive(1'b0, sv, sd, mr);
    tick();
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (q.size() != 0 && n < 300) begin cyc(1'b0, '0, 1'b1); n++; end
    chk(tag, 64'(q.size()), 64'd0);
    cyc(1'b0, '0, 1'b0);
  endtask

  initial begin
    int base, acc, cyc_n, prev_cnt, n;
    data_t d;
    drive(1'b1, 1'b0, '0, 1'b0); tick();
    drive(1'b1, 1'b0, '0, 1'b0); tick();
    drive(1'b0, 1'b0, '0, 1'b0);
    chk("rst_mvalid", 64'(m_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_sready", 64'(s_ready), 64'd1);
    tick();
    // single push of an all-ones word
    drive(1'b0, 1'b1, 52'hF_FFFF_FFFF_FFFF, 1'b0);
    chk("push_csb0", 64'(sram_csb0), 64'd0);
    chk("push_addr0", 64'(sram_addr0), 64'd0);
    tick();
    drive(1'b0, 1'b0, '0, 1'b0);
    chk("rd_csb1", 64'(sram_csb1), 64'd0);
    chk("rd_addr1", 64'(sram_addr1), 64'd0);
    chk("lat1_mvalid", 64'(m_valid), 64'd0);
    tick();
    drive(1'b0, 1'b0, '0, 1'b0);
    chk("lat2_mvalid", 64'(m_valid), 64'd0);
    tick();
    drive(1'b0, 1'b0, '0, 1'b1);
    chk("lat3_mvalid", 64'(m_valid), 64'd1);
    chk("lat3_data", 64'(m_data), 64'h000F_FFFF_FFFF_FFFF);
    tick();
    cyc(1'b0, '0, 1'b0);
    // fill with back-pressure
    base = wr_idx;
    for (int i = 0; i < 200; i++) cyc(1'b1, data_t'(i), 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0);
    chk("fill_accepted", 64'(wr_idx - base), 64'd130);
    chk("fill_last", 64'(q[q.size()-1]), 64'd129);
    chk("fill_count", 64'(count), 64'd130);
    chk("fill_sready", 64'(s_ready), 64'd0);
    chk("fill_csb1", 64'(sram_csb1), 64'd1);
    tick();
    for (int i = 0; i < 130; i++) begin
      drive(1'b0, 1'b0, '0, 1'b1);
      chk("drain_mvalid", 64'(m_valid), 64'd1);
      chk("drain_data", 64'(m_data), 64'(i));
      tick();
    end
    drive(1'b0, 1'b0, '0, 1'b1);
    chk("drained_mvalid", 64'(m_valid), 64'd0);
    chk("drained_count", 64'(count), 64'd0);
    tick();
    d = rnd();
    cyc(1'b1, d, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b1); chk("post_lat1", 64'(m_valid), 64'd0); tick();
    drive(1'b0, 1'b0, '0, 1'b1); chk("post_lat2", 64'(m_valid), 64'd0); tick();
    drive(1'b0, 1'b0, '0, 1'b1);
    chk("post_lat3", 64'(m_valid), 64'd1);
    chk("post_data", 64'(m_data), 64'(d));
    tick();
    cyc(1'b0, '0, 1'b0);
    // full-rate streaming
    prev_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      drive(1'b0, 1'b1, rnd(), 1'b1);
      if (i >= 3) chk("stream_mvalid", 64'(m_valid), 64'd1);
      if (i >= 4) chk("stream_count", 64'(count), 64'(prev_cnt));
      chk("stream_sready", 64'(s_ready), 64'd1);
      prev_cnt = int'(count);
      tick();
    end
    drain("stream_drain");
    // random valid/ready
    acc = 0; cyc_n = 0;
    while (acc < 1000 && cyc_n < 20000) begin
      drive(1'b0, 1'($urandom() % 2), rnd(), 1'($urandom() % 2));
      if (s_valid && s_ready) acc++;
      tick();
      cyc_n++;
    end
    chk("rand_done", 64'(acc), 64'd1000);
    drain("rand_drain");
    // reset while a read is in flight and one word is buffered
    cyc(1'b1, rnd(), 1'b0);
    cyc(1'b1, rnd(), 1'b0);
    cyc(1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0);
    chk("pre_rst_mvalid", 64'(m_valid), 64'd1);
    drive(1'b1, 1'b0, '0, 1'b0);
    tick();
    drive(1'b0, 1'b0, '0, 1'b0);
    chk("mid_rst_mvalid", 64'(m_valid), 64'd0);
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_sready", 64'(s_ready), 64'd1);
    tick();
    cyc(1'b1, 52'hABCDE, 1'b0);
    n = 0;
    while (!m_valid && n < 20) begin cyc(1'b0, '0, 1'b0); n++; end
    drive(1'b0, 1'b0, '0, 1'b1);
    chk("after_rst_mvalid", 64'(m_valid), 64'd1);
    chk("after_rst_data", 64'(m_data), 64'hABCDE);
    tick();
    drain("final_drain");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
